// File: rtl/bus_initiator_pkg.sv
// Shared types and constants for the peripheral-bus initiator.
// Build option: BUSI_BURST_EN enables multi-beat read bursts (see bus_initiator).
package bus_initiator_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  len;
    } cmd_t;

    localparam logic [31:0] PERI_BASE  = 32'h4000_0000;
    localparam logic [31:0] TH         = 32'h0000_0000;
    localparam logic [31:0] TL         = 32'h0000_0004;
    localparam logic [31:0] TCON       = 32'h0000_0008;
    localparam logic [31:0] LED        = 32'h0000_000C;
    localparam logic [31:0] SWITCH     = 32'h0000_0010;
    localparam logic [31:0] DIGI       = 32'h0000_0014;

    localparam logic [31:0] BEAT_BYTES = 32'd4;

endpackage

// File: rtl/bus_initiator_if.sv
// Host command/response ports plus the peripheral bus, as seen by the initiator.
// master = the initiator itself; slave = host agent and responders around it.
interface bus_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_len;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_last;
    logic        busy;

    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, rsp_ready, rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_last, busy,
               rd, wr, addr, wdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, rsp_ready, rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_last, busy,
               rd, wr, addr, wdata
    );

endinterface

// File: rtl/bus_initiator_cmd_fifo.sv
// Command FIFO: synchronous, async reset, DEPTH must be a power of two (>= 2).
// Pointers carry one wrap bit so full and empty are distinguishable without a counter.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;

    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = (wp == rp);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bus_initiator.sv
// Single-master peripheral-bus initiator: FIFO-buffered commands in, one response per beat out.
// Define BUSI_BURST_EN to honour cmd_len as extra read beats; otherwise every command is one beat.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    bus_initiator_if.master b
);

`ifdef BUSI_BURST_EN
    localparam int FW = $bits(cmd_t);
`else
    localparam int FW = $bits(cmd_t) - 4;
`endif

    cmd_t          cmd_in, head;
    logic [FW-1:0] push_d, pop_d;
    logic          full, empty, pop;
    logic [3:0]    head_beats;
    logic          unused_cfg;

    state_e        state;
    logic [3:0]    beats;
    logic          rd_q, wr_q;
    logic [31:0]   addr_q, wdata_q;
    logic          rsp_valid_q, rsp_write_q, rsp_last_q;
    logic [31:0]   rsp_rdata_q;

    assign cmd_in = '{we: b.cmd_we, addr: {b.cmd_addr[31:2], 2'b00},
                      wdata: b.cmd_wdata, len: b.cmd_len};

`ifdef BUSI_BURST_EN
    assign push_d     = cmd_in;
    assign head       = cmd_t'(pop_d);
    assign head_beats = head.we ? 4'd0 : head.len;
    assign unused_cfg = ^b.cmd_addr[1:0];
`else
    assign push_d     = {cmd_in.we, cmd_in.addr, cmd_in.wdata};
    assign head       = '{we: pop_d[64], addr: pop_d[63:32], wdata: pop_d[31:0], len: 4'd0};
    assign head_beats = 4'd0;
    assign unused_cfg = ^{b.cmd_addr[1:0], cmd_in.len, head.len};
`endif

    cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(FW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (b.cmd_valid),
        .din   (push_d),
        .pop   (pop),
        .dout  (pop_d),
        .full  (full),
        .empty (empty)
    );

    // A pop is exactly the moment a new command's bus registers get loaded.
    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            RESP:    pop = b.rsp_ready && (beats == 4'd0) && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            beats       <= 4'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            case (state)
                ACCESS: begin
                    rd_q        <= 1'b0;
                    wr_q        <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_q ? b.rdata : 32'h0;
                    rsp_write_q <= wr_q;
                    rsp_last_q  <= (beats == 4'd0);
                    state       <= RESP;
                end
                RESP: begin
                    if (b.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (beats != 4'd0) begin
                            beats  <= beats - 4'd1;
                            addr_q <= addr_q + BEAT_BYTES;
                            rd_q   <= 1'b1;
                            state  <= ACCESS;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Loading the next head overrides the IDLE fallback above.
            if (pop) begin
                addr_q  <= head.addr;
                wdata_q <= head.wdata;
                rd_q    <= !head.we;
                wr_q    <= head.we;
                beats   <= head_beats;
                state   <= ACCESS;
            end
        end
    end

    assign b.cmd_ready = !full;
    assign b.busy      = (state != IDLE) || !empty;
    assign b.rd        = rd_q;
    assign b.wr        = wr_q;
    assign b.addr      = addr_q;
    assign b.wdata     = wdata_q;
    assign b.rsp_valid = rsp_valid_q;
    assign b.rsp_rdata = rsp_rdata_q;
    assign b.rsp_write = rsp_write_q;
    assign b.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed + randomized bench for bus_initiator against a beat/response queue model.
module tb_bus_initiator;
    import bus_initiator_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_initiator_if bif();

    bus_initiator #(.CMD_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .b     (bif)
    );

    int          checks = 0;
    int          errors = 0;
    logic        fixed_mode = 1'b0;
    logic [31:0] fixed_val  = 32'h0;
    logic [31:0] salt       = 32'h5A5A_0F0F;

    // Responder stub: data is a simple function of the address unless pinned.
    assign bif.rdata = fixed_mode ? fixed_val : (bif.addr ^ salt);

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct packed { logic [31:0] rdata; logic write; logic last; } rsp_t;

    beat_t exp_bus[$], obs_bus[$];
    rsp_t  exp_rsp[$], obs_rsp[$];
    int    strobe_err = 0;
    int    hold_err   = 0;
    logic  prev_strobe = 1'b0;
    logic  prev_hold   = 1'b0;
    logic [33:0] prev_rsp = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stub(input logic [31:0] a);
        return fixed_mode ? fixed_val : (a ^ salt);
    endfunction

    // Reference: a read expands into len+1 word beats (burst build), anything else is one beat.
    task automatic model_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] l);
        int n;
        logic [31:0] ba;
        n  = 1;
`ifdef BUSI_BURST_EN
        if (!we) n = int'(l) + 1;
`endif
        ba = {a[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            exp_bus.push_back(beat_t'{we: we, addr: ba, wdata: we ? d : 32'h0});
            exp_rsp.push_back(rsp_t'{rdata: we ? 32'h0 : stub(ba), write: we, last: (i == n - 1)});
            ba = ba + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_strobe <= 1'b0;
            prev_hold   <= 1'b0;
        end else begin
            if (bif.rd && bif.wr) strobe_err <= strobe_err + 1;
            if ((bif.rd || bif.wr) && (prev_strobe || bif.addr[1:0] != 2'b00))
                strobe_err <= strobe_err + 1;
            if (bif.rd || bif.wr)
                obs_bus.push_back(beat_t'{we: bif.wr, addr: bif.addr,
                                          wdata: bif.wr ? bif.wdata : 32'h0});
            if (prev_hold && (!bif.rsp_valid ||
                {bif.rsp_rdata, bif.rsp_write, bif.rsp_last} != prev_rsp))
                hold_err <= hold_err + 1;
            if (bif.rsp_valid && bif.rsp_ready)
                obs_rsp.push_back(rsp_t'{rdata: bif.rsp_rdata, write: bif.rsp_write,
                                         last: bif.rsp_last});
            prev_strobe <= bif.rd || bif.wr;
            prev_hold   <= bif.rsp_valid && !bif.rsp_ready;
            prev_rsp    <= {bif.rsp_rdata, bif.rsp_write, bif.rsp_last};
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic try_push(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] l, output bit ok);
        bif.cmd_valid = 1'b1;
        bif.cmd_we    = we;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
        bif.cmd_len   = l;
        @(negedge clk);
        ok = bif.cmd_ready;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        if (ok) model_cmd(we, a, d, l);
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] l, input bit rnd);
        bit ok = 1'b0;
        int tries = 0;
        while (!ok && tries < 50) begin
            if (rnd) bif.rsp_ready = ($urandom_range(0, 3) != 0);
            try_push(we, a, d, l, ok);
            tries++;
        end
        check("push_accept", ok, 1);
    endtask

    task automatic drain(input string tag, input bit rnd);
        int guard = 0;
        while ((obs_rsp.size() < exp_rsp.size() || bif.busy) && guard < 2000) begin
            bif.rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        bif.rsp_ready = 1'b1;
        check({tag, "_timeout"}, guard < 2000, 1);
        check({tag, "_nbeats"}, obs_bus.size(), exp_bus.size());
        check({tag, "_nrsp"}, obs_rsp.size(), exp_rsp.size());
        while (exp_bus.size() > 0 && obs_bus.size() > 0)
            check({tag, "_beat"}, obs_bus.pop_front(), exp_bus.pop_front());
        while (exp_rsp.size() > 0 && obs_rsp.size() > 0)
            check({tag, "_rsp"}, obs_rsp.pop_front(), exp_rsp.pop_front());
        exp_bus.delete(); obs_bus.delete(); exp_rsp.delete(); obs_rsp.delete();
        check({tag, "_idle"}, {bif.busy, bif.cmd_ready, bif.rsp_valid}, 3'b010);
    endtask

    initial begin
        bit          ok;
        int          acc;
        logic [5:0]  mask;
        logic [33:0] held;

        reset = 1'b1;
        bif.cmd_valid = 1'b0; bif.cmd_we = 1'b0; bif.cmd_addr = '0;
        bif.cmd_wdata = '0;   bif.cmd_len = '0;  bif.rsp_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_bus", {bif.rd, bif.wr, bif.addr, bif.wdata}, 0);
        check("rst_rsp", {bif.rsp_valid, bif.rsp_rdata, bif.rsp_write, bif.rsp_last}, 0);
        check("rst_busy_ready", {bif.busy, bif.cmd_ready}, 2'b01);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single write: exact strobe and response timing.
        bif.rsp_ready = 1'b1;
        push(1'b1, PERI_BASE + TL, 32'h1234_5678, 4'd0, 1'b0);
        @(negedge clk);
        check("wr_before", {bif.rd, bif.wr, bif.busy}, 3'b001);
        @(negedge clk);
        check("wr_pulse", {bif.rd, bif.wr, bif.addr, bif.wdata},
              {1'b0, 1'b1, 32'h4000_0004, 32'h1234_5678});
        @(negedge clk);
        check("wr_rsp", {bif.wr, bif.rsp_valid, bif.rsp_write, bif.rsp_last, bif.rsp_rdata},
              {4'b0111, 32'h0});
        @(posedge clk); #1;
        drain("write", 1'b0);

        // Single read from an unaligned address with pinned responder data.
        fixed_mode = 1'b1; fixed_val = 32'h0000_00A5;
        push(1'b0, 32'h4000_0013, $urandom, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rd_pulse", {bif.rd, bif.wr, bif.addr}, {2'b10, PERI_BASE + SWITCH});
        @(negedge clk);
        check("rd_rsp", {bif.rsp_valid, bif.rsp_rdata, bif.rsp_write, bif.rsp_last},
              {1'b1, 32'hA5, 2'b01});
        @(posedge clk); #1;
        drain("read", 1'b0);
        fixed_mode = 1'b0;

        // Backpressure: depth 4 plus one executing, sixth push refused.
        bif.rsp_ready = 1'b0;
        acc = 0; mask = '0;
        for (int i = 0; i < 6; i++) begin
            try_push(1'b0, $urandom, $urandom, 4'd0, ok);
            mask[i] = ok;
            if (ok) acc++;
        end
        check("bp_accepted", acc, 5);
        check("bp_order", mask, 6'b011111);
        check("bp_ready", {bif.cmd_ready, bif.busy, bif.rsp_valid}, 3'b011);
        held = {bif.rsp_rdata, bif.rsp_write, bif.rsp_last};
        repeat (6) @(posedge clk); #1;
        check("bp_hold", {bif.rsp_valid, bif.rsp_rdata, bif.rsp_write, bif.rsp_last},
              {1'b1, held});
        drain("bp", 1'b0);

        // Burst reads (single beats when bursts are not built in), incl. address wrap.
        push(1'b0, PERI_BASE + TH, 32'h0, 4'd2, 1'b0);
        drain("burst", 1'b0);
        push(1'b0, 32'hFFFF_FFFC, 32'h0, 4'd1, 1'b0);
        drain("wrap", 1'b0);
        push(1'b1, PERI_BASE + LED, 32'hCAFE_0001, 4'd5, 1'b0);
        drain("wr_len", 1'b0);

        // Random mix with random response backpressure.
        salt = $urandom;
        for (int n = 0; n < 40; n++)
            push($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 3)), 1'b1);
        drain("random", 1'b1);

        // Reset during ACCESS of a read with two commands queued behind it.
        for (int i = 0; i < 4; i++) begin
            try_push(1'b0, PERI_BASE + DIGI, 32'h0, 4'd0, ok);
            check("rst_seq_push", ok, 1);
        end
        #1;
        check("rst_mid_access", {bif.rd, bif.wr, bif.busy}, 3'b101);
        reset = 1'b1;
        #1;
        check("rst_abort", {bif.rd, bif.wr, bif.rsp_valid, bif.cmd_ready, bif.busy}, 5'b00010);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        exp_bus.delete(); obs_bus.delete(); exp_rsp.delete(); obs_rsp.delete();
        repeat (10) @(posedge clk); #1;
        check("rst_quiet", obs_bus.size() + obs_rsp.size(), 0);
        check("rst_after", {bif.rd, bif.wr, bif.rsp_valid, bif.busy, bif.cmd_ready}, 5'b00001);

        check("strobe_rules", strobe_err, 0);
        check("rsp_stable", hold_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Single-master initiator for the CPU peripheral bus: it drives `rd`/`wr`/`addr`/`wdata`, samples `rdata` the same cycle, and returns per-beat responses. Commands arrive through a valid/ready port and are buffered in a small FIFO. Responses leave through a second valid/ready port. The block sits between a host agent (debug bridge or DMA front end) and the peripheral responders (timer, LED, switch, digit registers at 0x40000000–0x40000014). It is the initiator end of the same bus those responders serve.

## Interface
- `CMD_DEPTH`, default 4: command FIFO entries; must be a power of two, minimum 2.
- `clk`, input, 1 bit: clock.
- `reset`, input, 1 bit: asynchronous, active-high.
- `cmd_valid`, input, 1 bit: host command present.
- `cmd_ready`, output, 1 bit: FIFO not full.
- `cmd_we`, input, 1 bit: 1 = write, 0 = read.
- `cmd_addr`, input, 32 bits: byte address; bits [1:0] are ignored.
- `cmd_wdata`, input, 32 bits: write data.
- `cmd_len`, input, 4 bits: extra read beats (burst). Honoured only when `BUSI_BURST_EN` is defined.
- `rsp_valid`, output, 1 bit: response present.
- `rsp_ready`, input, 1 bit: host accepts the response.
- `rsp_rdata`, output, 32 bits: captured read data; 0 for writes.
- `rsp_write`, output, 1 bit: response belongs to a write.
- `rsp_last`, output, 1 bit: final beat of a command.
- `busy`, output, 1 bit: state is not IDLE, or the FIFO is non-empty.
- `rd`, output, 1 bit: bus read strobe.
- `wr`, output, 1 bit: bus write strobe.
- `addr`, output, 32 bits: bus address; bits [1:0] are always 0.
- `wdata`, output, 32 bits: bus write data.
- `rdata`, input, 32 bits: bus read data, combinational from the responder.

## Operation
- A command is pushed on the edge where `cmd_valid & cmd_ready` is high. `cmd_ready = !full`.
- State machine:
  - IDLE → ACCESS when the FIFO is non-empty. The head is popped and the bus registers are loaded.
  - ACCESS: exactly one of `rd`/`wr` is high for one cycle.
    - Read: `rdata` is captured into `rsp_rdata` at the end of the cycle.
    - Write: `rsp_rdata` is set to 0.
    - ACCESS always goes to RESP.
  - RESP: `rsp_valid` = 1. It holds until `rsp_valid & rsp_ready`. Then:
    - beats remain → ACCESS at `addr + 4`;
    - otherwise the FIFO is non-empty → ACCESS with the next head popped;
    - otherwise → IDLE.
- While in RESP, `rsp_*` outputs are stable. `rd`/`wr` are 0 in every state except ACCESS.
- `addr`/`wdata` hold their last values outside ACCESS.
- Burst address increment wraps modulo 2^32: 0xFFFFFFFC → 0x00000000.
- Writes are always single-beat; `cmd_len` is ignored for writes.
- Push and pop in the same cycle: both take effect and the entry count is unchanged. A push while full is not accepted.
- Reset values:
  - `rd`/`wr` = 0, `addr` = 0, `wdata` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_write` = 0, `rsp_last` = 0.
  - `busy` = 0, `cmd_ready` = 1.
  - FIFO empty, state IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously. Queued commands are discarded and no partial response is produced.

## Timing
- Command accepted at edge N:
  - popped at edge N+1, with the block idle;
  - `rd`/`wr` high from N+1 to N+2;
  - `rdata` sampled at N+2;
  - `rsp_valid` high from N+2.
- Peak throughput is one beat per 2 cycles, with `rsp_ready` tied high.
- `rsp_ready` may be high before `rsp_valid` rises. The response is then consumed at the first edge where `rsp_valid` is high.
- Maximum number of commands in flight: `CMD_DEPTH` in the FIFO plus 1 executing.

## Configuration
- `BUSI_BURST_EN` defined:
  - `cmd_len` is stored in the FIFO.
  - A read performs `cmd_len + 1` beats.
  - `rsp_last` is high only on the final beat.
- `BUSI_BURST_EN` undefined:
  - `cmd_len` is unused and not stored.
  - Every command is one beat and `rsp_last` is always 1 when `rsp_valid` is high.

## Structure
- Package `bus_initiator_pkg` contains:
  - state enum IDLE/ACCESS/RESP;
  - the command struct (`we`, `addr`, `wdata`, `len`);
  - peripheral address constants: `PERI_BASE` = 0x40000000, `TH` = 0x00, `TL` = 0x04, `TCON` = 0x08, `LED` = 0x0C, `SWITCH` = 0x10, `DIGI` = 0x14.
- One sub-module, `cmd_fifo`: synchronous FIFO with async reset, parameterised by depth and width, exposing `full`/`empty`/push/pop.

## Test plan
- Write, `cmd_we` = 1, addr 0x40000004, data 0x12345678:
  - `wr` high exactly one cycle with `addr` 0x40000004 and `wdata` 0x12345678;
  - then `rsp_valid`, `rsp_write` = 1, `rsp_rdata` = 0, `rsp_last` = 1.
- Read 0x40000013, stub `rdata` = 0x000000A5:
  - `rd` pulse with `addr` 0x40000010;
  - `rsp_rdata` = 0xA5 and `rsp_valid` high 2 cycles after the accept edge.
- Backpressure, `rsp_ready` = 0, 6 reads pushed with `CMD_DEPTH` = 4:
  - 5 commands accepted, then `cmd_ready` = 0;
  - `rsp_*` stable;
  - after releasing `rsp_ready`, the remaining 5 responses arrive in order.
- Burst, with `BUSI_BURST_EN`: read 0x40000000, `len` = 2:
  - three `rd` pulses at 0x00, 0x04, 0x08 offsets;
  - `rsp_last` high only on the third response.
- Wrap, burst read 0xFFFFFFFC with `len` = 1: second beat `addr` = 0x00000000.
- Reset asserted during ACCESS of a read with 2 queued commands:
  - `rd` drops immediately;
  - `rsp_valid` = 0, `cmd_ready` = 1, `busy` = 0;
  - no further bus activity after reset releases.
